// File: rtl/mem_port_arbiter.sv
`timescale 1ns / 1ps
// mem_port_arbiter
// Shares one single-port memory between three requesters: the UART loader
// (write only), the dcache (read or write) and the icache (refill reads only).
// Fixed priority UART > dcache > icache. After STARVE_MAX consecutive dcache
// grants while the icache waits, the icache beats the dcache once.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   u_*                       UART write request, ready, ack
//   d_*                       dcache request, ready, ack, read data
//   i_*                       icache request, ready, ack, read data
//   mem_addr/wdata/web/rdata  shared memory port
//   busy                      FSM is not idle
//   owner                     0 none, 1 UART, 2 dcache, 3 icache
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        u_valid,
  output logic        u_ready,
  input  logic [31:0] u_addr,
  input  logic [31:0] u_wdata,
  output logic        u_ack,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_web,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [1:0] OwnNone = 2'd0;
  localparam logic [1:0] OwnUart = 2'd1;
  localparam logic [1:0] OwnDc   = 2'd2;
  localparam logic [1:0] OwnIc   = 2'd3;

  localparam logic [2:0] LatLast   = 3'(MEM_LAT - 1);
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  state_e      state_q, state_d;
  logic [1:0]  owner_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] d_rdata_q, i_rdata_q;
  logic [2:0]  lat_q;
  logic [3:0]  starve_q;
  logic [1:0]  grant;
  logic        take;
  logic        rd_last;

  // Winner among current requesters; only acted on while idle.
  always_comb begin
    grant = OwnNone;
    if (u_valid) begin
      grant = OwnUart;
    end else if (i_valid && (starve_q == StarveMax)) begin
      grant = OwnIc;
    end else if (d_valid) begin
      grant = OwnDc;
    end else if (i_valid) begin
      grant = OwnIc;
    end
  end

  assign take    = (state_q == StIdle) && (grant != OwnNone);
  assign rd_last = (state_q == StAccess) && !we_q && (lat_q == LatLast);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (grant != OwnNone) state_d = StAccess;
      StAccess: if (we_q || (lat_q == LatLast)) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic: readies only while idle and out of reset, acks only in RESP.
  always_comb begin
    u_ready = 1'b0;
    d_ready = 1'b0;
    i_ready = 1'b0;
    u_ack   = 1'b0;
    d_ack   = 1'b0;
    i_ack   = 1'b0;
    if ((state_q == StIdle) && !rst) begin
      u_ready = (grant == OwnUart);
      d_ready = (grant == OwnDc);
      i_ready = (grant == OwnIc);
    end
    if ((state_q == StResp) && !rst) begin
      u_ack = (owner_q == OwnUart);
      d_ack = (owner_q == OwnDc);
      i_ack = (owner_q == OwnIc);
    end
  end

  assign mem_web   = (state_q == StAccess) && we_q;
  assign busy      = (state_q != StIdle);
  assign owner     = owner_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_rdata   = i_rdata_q;

  // Request latch, latency counter, read capture and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OwnNone;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
      lat_q     <= '0;
      starve_q  <= '0;
    end else begin
      if (take) begin
        owner_q <= grant;
        unique case (grant)
          OwnUart: begin
            addr_q  <= u_addr;
            wdata_q <= u_wdata;
            we_q    <= 1'b1;
          end
          OwnDc: begin
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            we_q    <= d_we;
          end
          default: begin
            addr_q  <= i_addr;
            wdata_q <= '0;
            we_q    <= 1'b0;
          end
        endcase
      end else if (state_q == StResp) begin
        owner_q <= OwnNone;
      end

      if (state_q == StAccess) begin
        lat_q <= lat_q + 3'd1;
      end else begin
        lat_q <= '0;
      end

      if (rd_last && (owner_q == OwnDc)) d_rdata_q <= mem_rdata;
      if (rd_last && (owner_q == OwnIc)) i_rdata_q <= mem_rdata;

      if (state_q == StIdle) begin
        if ((grant == OwnIc) || !i_valid) begin
          starve_q <= '0;
        end else if ((grant == OwnDc) && (starve_q != StarveMax)) begin
          starve_q <= starve_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns / 1ps
module tb_mem_port_arbiter;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;
  localparam int          NCYC       = 700;

  logic        clk = 1'b0;
  logic        rst;
  logic        u_valid, u_ready, u_ack;
  logic [31:0] u_addr, u_wdata;
  logic        d_valid, d_ready, d_we, d_ack;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        i_valid, i_ready, i_ack;
  logic [31:0] i_addr, i_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_web, busy;
  logic [1:0]  owner;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .u_valid  (u_valid),
    .u_ready  (u_ready),
    .u_addr   (u_addr),
    .u_wdata  (u_wdata),
    .u_ack    (u_ack),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_web  (mem_web),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .owner    (owner)
  );

  // Simple 16-word memory device behind the port.
  logic [31:0] mem_arr  [16];
  logic [31:0] seed_arr [16];
  logic        mem_load;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 16; k++) mem_arr[k] <= seed_arr[k];
    end else if (mem_web) begin
      mem_arr[mem_addr[5:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_arr[mem_addr[5:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 16; k++) seed_arr[k] = $urandom;
    seed_arr[4] = 32'hDEADBEEF;
    rst = 1'b1;
    u_valid = 1'b1;
    d_valid = 1'b1;
    i_valid = 1'b1;
    mem_load = 1'b1;
    tick();
    tick();
    mem_load = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({u_ready, d_ready, i_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 000", {u_ready, d_ready, i_ready});
    end
    n_cmp++;
    if ({busy, owner, mem_web, u_ack, d_ack, i_ack} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000", {busy, owner, mem_web, u_ack, d_ack, i_ack});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mem: got %h %h want 0 0", mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({d_rdata, i_rdata} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h %h want 0 0", d_rdata, i_rdata);
    end
    tick();
    rst = 1'b0;
    u_valid = 1'b0;
    d_valid = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_dcache_read();
    bit web_seen = 1'b0;
    tick();
    d_valid = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h10;
    d_wdata = $urandom;
    @(negedge clk);
    n_cmp++;
    if (d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dread_ready: got %b want 1", d_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      d_valid = 1'b0;
      @(negedge clk);
      if (mem_web === 1'b1) web_seen = 1'b1;
      n_cmp++;
      if (d_ack !== 1'(k == MEM_LAT + 1)) begin
        n_fail++;
        $display("FAIL dread_ack[%0d]: got %b want %b", k, d_ack, k == MEM_LAT + 1);
      end
      n_cmp++;
      if (busy !== 1'(k <= MEM_LAT + 1)) begin
        n_fail++;
        $display("FAIL dread_busy[%0d]: got %b want %b", k, busy, k <= MEM_LAT + 1);
      end
      if (k == 1) begin
        n_cmp++;
        if ({owner, mem_addr} !== {2'd2, 32'h10}) begin
          n_fail++;
          $display("FAIL dread_latch: got owner %0d addr %h want 2 00000010", owner, mem_addr);
        end
      end
      if (k == MEM_LAT + 1) begin
        n_cmp++;
        if (d_rdata !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL dread_data: got %h want deadbeef", d_rdata);
        end
      end
    end
    n_cmp++;
    if (web_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL dread_web: got %b want 0", web_seen);
    end
  endtask

  task automatic test_reset_mid();
    bit ack_seen = 1'b0;
    tick();
    d_valid = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h10;
    @(negedge clk);
    n_cmp++;
    if (d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_ready: got %b want 1", d_ready);
    end
    tick();
    d_valid = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({d_ack, u_ready, d_ready, i_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmid_during: got %b want 0000", {d_ack, u_ready, d_ready, i_ready});
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, owner, d_ack} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmid_after: got %b want 0000", {busy, owner, d_ack});
    end
    n_cmp++;
    if (d_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rmid_rdata: got %h want 0", d_rdata);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      if (d_ack === 1'b1) ack_seen = 1'b1;
    end
    n_cmp++;
    if (ack_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_no_ack: got %b want 0", ack_seen);
    end
    tick();
    d_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_reissue_ready: got %b want 1", d_ready);
    end
    for (int k = 1; k <= MEM_LAT + 1; k++) begin
      tick();
      d_valid = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if ({d_ack, d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL rmid_reissue_ack: got %b %h want 1 deadbeef", d_ack, d_rdata);
    end
  endtask

  task automatic test_uart_write();
    tick();
    u_valid = 1'b1;
    u_addr = 32'h1C090000;
    u_wdata = 32'h12345678;
    @(negedge clk);
    n_cmp++;
    if (u_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL uwr_ready: got %b want 1", u_ready);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      u_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (mem_web !== 1'(k == 1)) begin
        n_fail++;
        $display("FAIL uwr_web[%0d]: got %b want %b", k, mem_web, k == 1);
      end
      n_cmp++;
      if (u_ack !== 1'(k == 2)) begin
        n_fail++;
        $display("FAIL uwr_ack[%0d]: got %b want %b", k, u_ack, k == 2);
      end
      if (k == 1) begin
        n_cmp++;
        if ({mem_addr, mem_wdata} !== {32'h1C090000, 32'h12345678}) begin
          n_fail++;
          $display("FAIL uwr_bus: got %h %h want 1c090000 12345678", mem_addr, mem_wdata);
        end
      end
    end
  endtask

  task automatic test_all_three();
    int gq[$];
    int aq[$];
    int ack_cnt[3] = '{0, 0, 0};
    bit drop_u = 1'b0, drop_d = 1'b0, drop_i = 1'b0;
    int got;
    tick();
    u_valid = 1'b1;
    u_addr = $urandom;
    u_wdata = $urandom;
    d_valid = 1'b1;
    d_we = 1'b0;
    d_addr = $urandom;
    i_valid = 1'b1;
    i_addr = $urandom;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        tick();
        if (drop_u) u_valid = 1'b0;
        if (drop_d) d_valid = 1'b0;
        if (drop_i) i_valid = 1'b0;
      end
      @(negedge clk);
      if (u_ready === 1'b1) begin gq.push_back(1); drop_u = 1'b1; end
      if (d_ready === 1'b1) begin gq.push_back(2); drop_d = 1'b1; end
      if (i_ready === 1'b1) begin gq.push_back(3); drop_i = 1'b1; end
      if (u_ack === 1'b1) begin aq.push_back(1); ack_cnt[0]++; end
      if (d_ack === 1'b1) begin aq.push_back(2); ack_cnt[1]++; end
      if (i_ack === 1'b1) begin aq.push_back(3); ack_cnt[2]++; end
    end
    n_cmp++;
    if (gq.size() != 3) begin
      n_fail++;
      $display("FAIL all3_grants: got %0d grants want 3", gq.size());
    end
    for (int n = 0; n < 3; n++) begin
      got = (n < gq.size()) ? gq[n] : -1;
      n_cmp++;
      if (got != n + 1) begin
        n_fail++;
        $display("FAIL all3_grant[%0d]: got %0d want %0d", n, got, n + 1);
      end
      got = (n < aq.size()) ? aq[n] : -1;
      n_cmp++;
      if (got != n + 1) begin
        n_fail++;
        $display("FAIL all3_ack[%0d]: got %0d want %0d", n, got, n + 1);
      end
      n_cmp++;
      if (ack_cnt[n] != 1) begin
        n_fail++;
        $display("FAIL all3_ackcnt[%0d]: got %0d want 1", n, ack_cnt[n]);
      end
    end
  endtask

  task automatic test_starvation();
    int gq[$];
    bit d_g = 1'b0, i_g = 1'b0, d_a = 1'b0, i_a = 1'b0, stop = 1'b0;
    int got, want;
    tick();
    d_valid = 1'b1;
    d_we = 1'b1;
    d_addr = $urandom;
    d_wdata = $urandom;
    i_valid = 1'b1;
    i_addr = $urandom;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) begin
        tick();
        if (d_g) d_valid = 1'b0;
        if (i_g) i_valid = 1'b0;
        if (d_a) begin d_valid = 1'b1; d_addr = $urandom; d_wdata = $urandom; end
        if (i_a) begin i_valid = 1'b1; i_addr = $urandom; end
        if (stop) begin d_valid = 1'b0; i_valid = 1'b0; end
      end
      @(negedge clk);
      d_g = (d_ready === 1'b1);
      i_g = (i_ready === 1'b1);
      d_a = (d_ack === 1'b1);
      i_a = (i_ack === 1'b1);
      if (d_g) gq.push_back(2);
      if (i_g) gq.push_back(3);
      if (gq.size() >= 10) stop = 1'b1;
    end
    n_cmp++;
    if (gq.size() < 10) begin
      n_fail++;
      $display("FAIL starve_count: got %0d grants want >= 10", gq.size());
    end
    // icache wins every (STARVE_MAX+1)-th grant while dcache keeps asking.
    for (int n = 0; n < 10; n++) begin
      got  = (n < gq.size()) ? gq[n] : -1;
      want = ((n % (STARVE_MAX + 1)) == STARVE_MAX) ? 3 : 2;
      n_cmp++;
      if (got != want) begin
        n_fail++;
        $display("FAIL starve_grant[%0d]: got %0d want %0d", n, got, want);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [16];
    bit          v [3] = '{0, 0, 0};
    bit          pend [3] = '{0, 0, 0};
    bit          granted [3] = '{0, 0, 0};
    bit          we_r [3] = '{0, 0, 0};
    bit          txn_we [3] = '{0, 0, 0};
    logic [31:0] a_r [3] = '{0, 0, 0};
    logic [31:0] w_r [3] = '{0, 0, 0};
    logic [31:0] exp_rd [3] = '{0, 0, 0};
    int          ack_t [3] = '{-1, -1, -1};
    int          free_t = 0, web_t = -1, starve = 0, g;
    logic [31:0] cur_addr = 0, cur_wdata = 0, last_d = 0, last_i = 0;
    bit          cur_we = 1'b0, have_txn = 1'b0, have_d = 1'b0, have_i = 1'b0;
    logic [1:0]  cur_owner = 2'd0;
    logic [2:0]  exp_rdy, exp_ack;
    for (int k = 0; k < 16; k++) begin
      seed_arr[k] = $urandom;
      ref_mem[k]  = seed_arr[k];
    end
    tick();
    mem_load = 1'b1;
    tick();
    mem_load = 1'b0;
    for (int t = 0; t < NCYC + 30; t++) begin
      tick();
      for (int p = 0; p < 3; p++) begin
        if (granted[p]) begin v[p] = 1'b0; granted[p] = 1'b0; end
        if (t < NCYC && !v[p] && !pend[p] && $urandom_range(0, 2) == 0) begin
          v[p]   = 1'b1;
          a_r[p] = $urandom;
          w_r[p] = $urandom;
          we_r[p] = (p == 0) ? 1'b1 : (p == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end
      end
      u_valid = v[0]; u_addr = a_r[0]; u_wdata = w_r[0];
      d_valid = v[1]; d_addr = a_r[1]; d_wdata = w_r[1]; d_we = we_r[1];
      i_valid = v[2]; i_addr = a_r[2];
      @(negedge clk);
      g = -1;
      if (t >= free_t) begin
        if (v[0]) g = 0;
        else if (v[2] && starve == STARVE_MAX) g = 2;
        else if (v[1]) g = 1;
        else if (v[2]) g = 2;
      end
      exp_rdy = {g == 0, g == 1, g == 2};
      exp_ack = {pend[0] && ack_t[0] == t, pend[1] && ack_t[1] == t, pend[2] && ack_t[2] == t};
      n_cmp++;
      if ({u_ready, d_ready, i_ready} !== exp_rdy) begin
        n_fail++;
        $display("FAIL rnd_ready@%0d: got %b want %b", t, {u_ready, d_ready, i_ready}, exp_rdy);
      end
      n_cmp++;
      if ({u_ack, d_ack, i_ack} !== exp_ack) begin
        n_fail++;
        $display("FAIL rnd_ack@%0d: got %b want %b", t, {u_ack, d_ack, i_ack}, exp_ack);
      end
      n_cmp++;
      if ({busy, owner} !== {1'(t < free_t), (t < free_t) ? cur_owner : 2'd0}) begin
        n_fail++;
        $display("FAIL rnd_busy_owner@%0d: got %b %0d want %b %0d", t, busy, owner,
                 t < free_t, (t < free_t) ? cur_owner : 2'd0);
      end
      n_cmp++;
      if (mem_web !== 1'(t == web_t)) begin
        n_fail++;
        $display("FAIL rnd_web@%0d: got %b want %b", t, mem_web, t == web_t);
      end
      if (have_txn) begin
        n_cmp++;
        if (mem_addr !== cur_addr || (cur_we && mem_wdata !== cur_wdata)) begin
          n_fail++;
          $display("FAIL rnd_bus@%0d: got %h %h want %h %h", t, mem_addr, mem_wdata,
                   cur_addr, cur_wdata);
        end
      end
      if (exp_ack[1] && !txn_we[1]) begin last_d = exp_rd[1]; have_d = 1'b1; end
      if (exp_ack[0] && !txn_we[2]) begin last_i = exp_rd[2]; have_i = 1'b1; end
      if (have_d) begin
        n_cmp++;
        if (d_rdata !== last_d) begin
          n_fail++;
          $display("FAIL rnd_drdata@%0d: got %h want %h", t, d_rdata, last_d);
        end
      end
      if (have_i) begin
        n_cmp++;
        if (i_rdata !== last_i) begin
          n_fail++;
          $display("FAIL rnd_irdata@%0d: got %h want %h", t, i_rdata, last_i);
        end
      end
      for (int p = 0; p < 3; p++) if (exp_ack[2-p]) pend[p] = 1'b0;
      if (t >= free_t) begin
        if (g == 2 || !v[2]) starve = 0;
        else if (g == 1 && starve < STARVE_MAX) starve++;
      end
      if (g >= 0) begin
        granted[g] = 1'b1;
        pend[g]    = 1'b1;
        txn_we[g]  = we_r[g];
        if (we_r[g]) begin
          ack_t[g] = t + 2;
          free_t   = t + 3;
          web_t    = t + 1;
          ref_mem[a_r[g][5:2]] = w_r[g];
        end else begin
          ack_t[g]  = t + MEM_LAT + 1;
          free_t    = t + MEM_LAT + 2;
          exp_rd[g] = ref_mem[a_r[g][5:2]];
        end
        cur_addr  = a_r[g];
        cur_wdata = w_r[g];
        cur_we    = we_r[g];
        cur_owner = 2'(g + 1);
        have_txn  = 1'b1;
      end
    end
    n_cmp++;
    if ({pend[0], pend[1], pend[2], v[0], v[1], v[2]} !== 6'd0) begin
      n_fail++;
      $display("FAIL rnd_drain: got %b want 000000", {pend[0], pend[1], pend[2], v[0], v[1], v[2]});
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_load = 1'b0;
    u_valid = 1'b0; u_addr = '0; u_wdata = '0;
    d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    i_valid = 1'b0; i_addr = '0;
    test_reset();
    test_dcache_read();
    test_reset_mid();
    test_uart_write();
    test_all_three();
    test_starvation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: memory port read latency in clk cycles, legal range 1..7.
REQ-002 Parameter STARVE_MAX, default 4: consecutive dcache grants tolerated while icache waits, legal range 1..15.
REQ-003 clk  in  1  single clock for all state.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 u_valid  in  1  UART loader write request.
REQ-006 u_ready  out  1  UART request accepted this cycle.
REQ-007 u_addr, u_wdata  in  32 each  UART write address and data.
REQ-008 u_ack  out  1  UART write complete (1-cycle pulse).
REQ-009 d_valid  in  1  dcache request.
REQ-010 d_ready  out  1  dcache request accepted this cycle.
REQ-011 d_we  in  1  1 = write, 0 = read.
REQ-012 d_addr, d_wdata  in  32 each  dcache address and write data.
REQ-013 d_ack  out  1  dcache complete (1-cycle pulse).
REQ-014 d_rdata  out  32  dcache read data, valid with d_ack.
REQ-015 i_valid  in  1  icache refill read request.
REQ-016 i_ready  out  1  icache request accepted this cycle.
REQ-017 i_addr  in  32  icache address.
REQ-018 i_ack  out  1  icache complete (1-cycle pulse).
REQ-019 i_rdata  out  32  icache read data, valid with i_ack.
REQ-020 mem_addr, mem_wdata  out  32 each  shared memory port address and write data.
REQ-021 mem_web  out  1  memory write enable, active-high.
REQ-022 mem_rdata  in  32  memory read data.
REQ-023 busy  out  1  high in any state other than IDLE.
REQ-024 owner  out  2  current owner: 0 none, 1 UART, 2 dcache, 3 icache.

Function
REQ-025 FSM states: IDLE, ACCESS, RESP.
REQ-026 In IDLE, exactly one ready is driven high, combinationally, for the winning valid requester; all readies are low in ACCESS and RESP.
REQ-027 Priority: UART > dcache > icache, except icache beats dcache when starve_cnt == STARVE_MAX; UART always wins.
REQ-028 Handshake: valid && ready latches addr, wdata and we (UART is always a write, icache always a read) and the owner id, then the FSM goes to ACCESS.
REQ-029 A requester holds valid, addr and data stable until it sees ready; it issues no new request before its ack.
REQ-030 ACCESS, write: mem_web is high for exactly 1 cycle, then the FSM goes to RESP.
REQ-031 ACCESS, read: mem_web stays low; the FSM holds for MEM_LAT cycles, captures mem_rdata on the last one, then goes to RESP.
REQ-032 mem_addr and mem_wdata drive the latched values throughout ACCESS and keep them in IDLE and RESP.
REQ-033 RESP lasts 1 cycle: the owner's ack pulses, rdata is presented for reads, then the FSM returns to IDLE.
REQ-034 Latency from handshake cycle to ack: write = 2 cycles; read = MEM_LAT+1 cycles.
REQ-035 Back-to-back: a new handshake is possible in the IDLE cycle directly after RESP, giving 3 cycles per write transaction.
REQ-036 d_rdata and i_rdata hold their last captured value until the next read for that port.
REQ-037 starve_cnt (4 bit), updated at each handshake:
- +1 on a dcache grant while i_valid is high, saturating at STARVE_MAX;
- cleared on an icache grant;
- cleared in any IDLE cycle with i_valid low.
REQ-038 If all three valids rise in the same cycle, UART is granted; dcache is granted after it, then icache, unless the starvation rule applies.
REQ-039 mem_web is never high outside ACCESS, and never high for a read.
REQ-040 owner is set at the handshake and returns to 0 on entry to IDLE.

Reset
REQ-041 On rst high at a clk edge, including mid-transaction:
- state = IDLE, owner = 0, starve_cnt = 0;
- mem_web = 0, all acks = 0;
- mem_addr, mem_wdata, d_rdata and i_rdata = 0.
REQ-042 A transaction interrupted by reset is dropped without an ack; the requester reissues it.
REQ-043 While rst is high, all readies are low.

Verification
REQ-044 d_valid read, addr 0x10, MEM_LAT=2, memory returns 0xDEADBEEF -> d_ack 3 cycles after the handshake, d_rdata = 0xDEADBEEF, mem_web never high.
REQ-045 u_valid, d_valid and i_valid all raised in the same cycle -> grant order UART, dcache, icache; each ack pulses exactly once, in that order.
REQ-046 d_valid held continuously with i_valid high, STARVE_MAX=4 -> after 4 dcache grants the 5th grant goes to icache, then starve_cnt = 0.
REQ-047 u write addr 0x1C090000, data 0x12345678 -> mem_web high 1 cycle with those values; u_ack 2 cycles after the handshake.
REQ-048 rst asserted in the 2nd ACCESS cycle of a read -> next cycle IDLE, busy = 0, no d_ack; the reissued request completes normally.
